pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the OPEN_MIPS core. It generalises the
//  fixed-field stage latches to N lanes of opaque payload, each with its own valid bit.
//  It obeys the global stall vector and adds flush (exception kill) and per-lane kill.
//  It also carries saturating bubble/hold/flush event counters for pipeline profiling.
// PARAMETERS
//  DATA_W         32  payload bits per lane; all fields of one lane, including write enables, packed
//  LANES           1  number of parallel lanes (1..4)
//  STALL_W         6  width of the global stall vector
//  STAGE_IDX       4  index of this stage's bit in stall; the next stage's bit is STAGE_IDX+1
//  ZERO_ON_BUBBLE  1  1: a bubble or kill also zeroes that lane's data; 0: clear valid only, data held
//  CNT_W          16  width of each event counter
// PORTS
//  clk         in   1               rising-edge clock
//  rst         in   1               asynchronous reset, active-high
//  stall       in   STALL_W         global stall vector; 1 = Stop
//  flush       in   1               kill every lane this cycle (exception/eret)
//  in_kill     in   LANES           per-lane kill; the lane captures a bubble instead of its data
//  in_valid    in   LANES           per-lane valid from the upstream stage
//  in_data     in   LANES*DATA_W    lane i = in_data[i*DATA_W +: DATA_W]
//  out_valid   out  LANES           registered per-lane valid
//  out_data    out  LANES*DATA_W    registered payload
//  cnt_clr     in   1               synchronous clear of all counters
//  bubble_cnt  out  CNT_W           cycles on which a stall bubble was inserted
//  hold_cnt    out  CNT_W           cycles on which the register held its contents
//  flush_cnt   out  CNT_W           cycles on which flush was asserted (outside reset)
// BEHAVIOUR
//  - Reset: while rst=1, out_valid=0, out_data=0 and all counters=0, asynchronously.
//  - Define s_cur = stall[STAGE_IDX].
//  - Define s_nxt = stall[STAGE_IDX+1]; when STAGE_IDX==STALL_W-1, s_nxt is tied to 0.
//  - Elaboration check: STAGE_IDX must be < STALL_W; LANES must be 1..4; otherwise $error.
//  - Per-cycle action, evaluated at posedge clk in strict priority order:
//    1 FLUSH : flush=1 -> all out_valid<=0; data<=0 when ZERO_ON_BUBBLE=1. Overrides any stall.
//    2 BUBBLE: s_cur=1 and s_nxt=0 -> all out_valid<=0, data as in FLUSH.
//              The upstream instruction is held upstream; this stage emits a NOP.
//    3 CAPT  : s_cur=0 -> lane i: out_valid[i]<=in_valid[i]&~in_kill[i] and out_data lane<=in_data lane.
//              A killed lane is treated as in FLUSH (data zeroed when ZERO_ON_BUBBLE=1).
//    4 HOLD  : s_cur=1 and s_nxt=1 -> all outputs keep their value; in_kill is ignored.
//  - Latency: 1 cycle from in_* to out_*. No combinational path from in_* to out_*.
//  - Lanes are independent except under FLUSH, BUBBLE and HOLD, which act on all lanes together.
//  - Counters, updated at posedge, only when rst=0:
//    - cnt_clr=1 -> all counters<=0. Clear has priority over increment in the same cycle.
//    - Else exactly one of flush_cnt, bubble_cnt or hold_cnt increments, selected by the action taken.
//    - CAPT increments no counter.
//    - Counters saturate at all-ones and never wrap.
//  - Reset mid-operation: outputs clear immediately on rst rise (no clock needed).
//    The first capture happens on the first posedge after rst falls, per the normal priority.
//  - X-safety: out_data of an invalid lane is don't-care when ZERO_ON_BUBBLE=0; consumers gate on out_valid.
// TESTING
//  T1 Reset: drive rst=1 mid-stream with out_valid=1, out_data=32'hDEADBEEF.
//     Required: out_valid=0, out_data=0 and counters=0 before the next clk edge.
//  T2 Capture: stall=6'b0, in_valid=1, in_data=32'h1234_5678.
//     Required: out_valid=1 and out_data=32'h1234_5678 one cycle later; all counters unchanged.
//  T3 Bubble vs hold (STAGE_IDX=4):
//     stall=6'b010000 for 2 cycles -> out_valid=0, out_data=0, bubble_cnt=2.
//     Then stall=6'b110000 for 3 cycles -> out_valid stays 0, hold_cnt=3.
//  T4 Flush priority: stall=6'b010000 together with flush=1 for 1 cycle.
//     Required: out_valid=0, flush_cnt=1, bubble_cnt unchanged.
//  T5 LANES=2, stall=0, in_valid=2'b11, in_kill=2'b10, data={32'hAAAA_AAAA,32'h5555_5555}.
//     Required: out_valid=2'b01, lane0=32'h5555_5555, lane1=0.
//  T6 CNT_W=4: hold for 20 cycles -> hold_cnt saturates at 4'hF.
//     Then cnt_clr=1 together with hold -> all counters=0 on the next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: N lanes of opaque payload with per-lane valid,
// obeying the global stall vector, flush and per-lane kill, plus saturating event counters.
module pipe_stage_reg #(
    parameter int DATA_W         = 32,
    parameter int LANES          = 1,
    parameter int STALL_W        = 6,
    parameter int STAGE_IDX      = 4,
    parameter int ZERO_ON_BUBBLE = 1,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES-1:0]          in_kill,
    input  logic [LANES-1:0]          in_valid,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic [LANES-1:0]          out_valid,
    output logic [LANES*DATA_W-1:0]   out_data,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          bubble_cnt,
    output logic [CNT_W-1:0]          hold_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    typedef enum logic [1:0] {
        ACT_CAPT   = 2'd0,
        ACT_FLUSH  = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_HOLD   = 2'd3
    } act_e;

    if (STAGE_IDX < 0 || STAGE_IDX >= STALL_W) begin : g_bad_stage_idx
        $error("pipe_stage_reg: STAGE_IDX must be in 0..STALL_W-1");
    end
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("pipe_stage_reg: LANES must be in 1..4");
    end

    localparam bit ZERO_DATA = (ZERO_ON_BUBBLE != 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    logic [1:0]              stall_sel_s;
    logic                    s_cur_s;
    logic                    s_nxt_s;
    act_e                    act_s;
    logic [LANES-1:0]        valid_nxt_s;
    logic [LANES*DATA_W-1:0] data_nxt_s;
    logic [LANES-1:0]        valid_r;
    logic [LANES*DATA_W-1:0] data_r;
    logic [CNT_W-1:0]        bubble_cnt_r;
    logic [CNT_W-1:0]        hold_cnt_r;
    logic [CNT_W-1:0]        flush_cnt_r;

    // A zero is shifted in above the top stall bit, so the last stage sees s_nxt = 0.
    assign stall_sel_s = 2'({1'b0, stall} >> STAGE_IDX);
    assign s_cur_s     = stall_sel_s[0];
    assign s_nxt_s     = stall_sel_s[1];

    // Priority decode of this cycle's action.
    always_comb begin
        act_s = ACT_CAPT;
        if (flush) begin
            act_s = ACT_FLUSH;
        end else if (!s_cur_s) begin
            act_s = ACT_CAPT;
        end else if (!s_nxt_s) begin
            act_s = ACT_BUBBLE;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Next lane contents for the selected action.
    always_comb begin
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        for (int i = 0; i < LANES; i++) begin
            case (act_s)
                ACT_FLUSH, ACT_BUBBLE: begin
                    valid_nxt_s[i] = 1'b0;
                    if (ZERO_DATA) begin
                        data_nxt_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                    end else begin
                        data_nxt_s[i*DATA_W +: DATA_W] = data_r[i*DATA_W +: DATA_W];
                    end
                end
                ACT_CAPT: begin
                    valid_nxt_s[i] = in_valid[i] & ~in_kill[i];
                    if (in_kill[i] && ZERO_DATA) begin
                        data_nxt_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                    end else begin
                        data_nxt_s[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
                    end
                end
                ACT_HOLD: begin
                    valid_nxt_s[i]                 = valid_r[i];
                    data_nxt_s[i*DATA_W +: DATA_W] = data_r[i*DATA_W +: DATA_W];
                end
                default: begin
                    valid_nxt_s[i]                 = valid_r[i];
                    data_nxt_s[i*DATA_W +: DATA_W] = data_r[i*DATA_W +: DATA_W];
                end
            endcase
        end
    end

    // Lane payload and valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {LANES{1'b0}};
            data_r  <= {(LANES*DATA_W){1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // Profiling counters; clear wins over increment, CAPT counts nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            hold_cnt_r   <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            hold_cnt_r   <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (act_s)
                ACT_FLUSH:  flush_cnt_r  <= sat_inc(flush_cnt_r);
                ACT_BUBBLE: bubble_cnt_r <= sat_inc(bubble_cnt_r);
                ACT_HOLD:   hold_cnt_r   <= sat_inc(hold_cnt_r);
                default:    flush_cnt_r  <= flush_cnt_r;
            endcase
        end
    end

    assign out_valid  = valid_r;
    assign out_data   = data_r;
    assign bubble_cnt = bubble_cnt_r;
    assign hold_cnt   = hold_cnt_r;
    assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table on a 2-lane / 4-bit-counter instance,
// plus hand sequences for saturation, async reset, bubble/hold, flush and the top-stage tie-off.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cnt_clr;
    logic [1:0]  in_kill;
    logic [1:0]  in_valid;
    logic [63:0] in_data;

    logic [1:0]  d_valid;
    logic [63:0] d_data;
    logic [3:0]  d_bub, d_hold, d_fl;

    logic        o_valid;
    logic [31:0] o_data;
    logic [15:0] o_bub, o_hold, o_fl;

    logic        h_valid;
    logic [31:0] h_data;
    logic [15:0] h_bub, h_hold, h_fl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .LANES(2), .STALL_W(6), .STAGE_IDX(4),
                     .ZERO_ON_BUBBLE(1), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_kill(in_kill),
        .in_valid(in_valid), .in_data(in_data), .out_valid(d_valid), .out_data(d_data),
        .cnt_clr(cnt_clr), .bubble_cnt(d_bub), .hold_cnt(d_hold), .flush_cnt(d_fl));

    pipe_stage_reg u_one (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_kill(in_kill[0]),
        .in_valid(in_valid[0]), .in_data(in_data[31:0]), .out_valid(o_valid), .out_data(o_data),
        .cnt_clr(cnt_clr), .bubble_cnt(o_bub), .hold_cnt(o_hold), .flush_cnt(o_fl));

    pipe_stage_reg #(.STAGE_IDX(5), .ZERO_ON_BUBBLE(0)) u_top (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_kill(in_kill[0]),
        .in_valid(in_valid[0]), .in_data(in_data[31:0]), .out_valid(h_valid), .out_data(h_data),
        .cnt_clr(cnt_clr), .bubble_cnt(h_bub), .hold_cnt(h_hold), .flush_cnt(h_fl));

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        clr;
        logic [1:0]  kill;
        logic [1:0]  valid;
        logic [63:0] data;
        logic [1:0]  e_valid;
        logic [63:0] e_data;
        logic [3:0]  e_bub;
        logic [3:0]  e_hold;
        logic [3:0]  e_fl;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall, flush, clr, kill, valid, data, exp valid, exp data, bub, hold, fl
        tbl[0]  = '{6'b000000, 1'b0, 1'b0, 2'b00, 2'b11, {32'hAAAA_AAAA, 32'h5555_5555},
                    2'b11, {32'hAAAA_AAAA, 32'h5555_5555}, 4'd0, 4'd0, 4'd0};
        tbl[1]  = '{6'b000000, 1'b0, 1'b0, 2'b10, 2'b11, {32'hAAAA_AAAA, 32'h5555_5555},
                    2'b01, {32'h0000_0000, 32'h5555_5555}, 4'd0, 4'd0, 4'd0};
        tbl[2]  = '{6'b000000, 1'b0, 1'b0, 2'b00, 2'b10, {32'h1111_1111, 32'h2222_2222},
                    2'b10, {32'h1111_1111, 32'h2222_2222}, 4'd0, 4'd0, 4'd0};
        tbl[3]  = '{6'b010000, 1'b0, 1'b0, 2'b00, 2'b11, {32'h9999_9999, 32'h9999_9999},
                    2'b00, 64'h0, 4'd1, 4'd0, 4'd0};
        tbl[4]  = '{6'b000000, 1'b0, 1'b0, 2'b00, 2'b11, {32'h3333_3333, 32'h4444_4444},
                    2'b11, {32'h3333_3333, 32'h4444_4444}, 4'd1, 4'd0, 4'd0};
        tbl[5]  = '{6'b110000, 1'b0, 1'b0, 2'b11, 2'b11, {32'hDEAD_0001, 32'hDEAD_0002},
                    2'b11, {32'h3333_3333, 32'h4444_4444}, 4'd1, 4'd1, 4'd0};
        tbl[6]  = '{6'b110000, 1'b0, 1'b0, 2'b00, 2'b00, {32'hDEAD_0003, 32'hDEAD_0004},
                    2'b11, {32'h3333_3333, 32'h4444_4444}, 4'd1, 4'd2, 4'd0};
        tbl[7]  = '{6'b110000, 1'b1, 1'b0, 2'b00, 2'b11, {32'hDEAD_0005, 32'hDEAD_0006},
                    2'b00, 64'h0, 4'd1, 4'd2, 4'd1};
        tbl[8]  = '{6'b010000, 1'b1, 1'b0, 2'b00, 2'b11, {32'hDEAD_0007, 32'hDEAD_0008},
                    2'b00, 64'h0, 4'd1, 4'd2, 4'd2};
        tbl[9]  = '{6'b100000, 1'b0, 1'b0, 2'b00, 2'b01, {32'hCAFE_0001, 32'hCAFE_0002},
                    2'b01, {32'hCAFE_0001, 32'hCAFE_0002}, 4'd1, 4'd2, 4'd2};
        tbl[10] = '{6'b001111, 1'b0, 1'b0, 2'b01, 2'b11, {32'h7777_7777, 32'h8888_8888},
                    2'b10, {32'h7777_7777, 32'h0000_0000}, 4'd1, 4'd2, 4'd2};
        tbl[11] = '{6'b000000, 1'b0, 1'b1, 2'b00, 2'b00, {32'h0123_4567, 32'h89AB_CDEF},
                    2'b00, {32'h0123_4567, 32'h89AB_CDEF}, 4'd0, 4'd0, 4'd0};
        tbl[12] = '{6'b110000, 1'b0, 1'b1, 2'b00, 2'b11, {32'hFFFF_0000, 32'h0000_FFFF},
                    2'b00, {32'h0123_4567, 32'h89AB_CDEF}, 4'd0, 4'd0, 4'd0};
        tbl[13] = '{6'b110000, 1'b0, 1'b0, 2'b00, 2'b11, {32'hFFFF_0000, 32'h0000_FFFF},
                    2'b00, {32'h0123_4567, 32'h89AB_CDEF}, 4'd0, 4'd1, 4'd0};

        rst = 1'b1; stall = 6'b0; flush = 1'b0; cnt_clr = 1'b0;
        in_kill = 2'b00; in_valid = 2'b00; in_data = 64'h0;
        step();
        step();
        chk("rst_valid", {62'h0, d_valid}, 64'h0);
        chk("rst_data", d_data, 64'h0);
        chk("rst_cnts", {52'h0, d_bub, d_hold, d_fl}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            stall = tbl[i].stall; flush = tbl[i].flush; cnt_clr = tbl[i].clr;
            in_kill = tbl[i].kill; in_valid = tbl[i].valid; in_data = tbl[i].data;
            step();
            chk($sformatf("v%0d_valid", i), {62'h0, d_valid}, {62'h0, tbl[i].e_valid});
            chk($sformatf("v%0d_data", i), d_data, tbl[i].e_data);
            chk($sformatf("v%0d_bub", i), {60'h0, d_bub}, {60'h0, tbl[i].e_bub});
            chk($sformatf("v%0d_hold", i), {60'h0, d_hold}, {60'h0, tbl[i].e_hold});
            chk($sformatf("v%0d_flush", i), {60'h0, d_fl}, {60'h0, tbl[i].e_fl});
        end

        // Saturation: hold_cnt is 1 here; 14 more holds reach 15, 6 more must not wrap.
        stall = 6'b110000; flush = 1'b0; cnt_clr = 1'b0;
        repeat (14) step();
        chk("sat_reach", {60'h0, d_hold}, 64'hF);
        repeat (6) step();
        chk("sat_stay", {60'h0, d_hold}, 64'hF);
        cnt_clr = 1'b1;
        step();
        chk("clr_hold", {52'h0, d_bub, d_hold, d_fl}, 64'h0);
        cnt_clr = 1'b0;
        step();
        chk("after_clr_hold", {60'h0, d_hold}, 64'h1);

        // Async reset mid-stream, no clock edge in between.
        stall = 6'b0; in_kill = 2'b00; in_valid = 2'b01; in_data = {32'h0, 32'hDEAD_BEEF};
        step();
        chk("pre_rst_valid", {63'h0, o_valid}, 64'h1);
        chk("pre_rst_data", {32'h0, o_data}, 64'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {63'h0, o_valid}, 64'h0);
        chk("async_data", {32'h0, o_data}, 64'h0);
        chk("async_cnts", {16'h0, o_bub, o_hold, o_fl}, 64'h0);
        chk("async_dut", {62'h0, d_valid}, 64'h0);
        rst = 1'b0;

        // First edge after reset captures.
        in_data = {32'h0, 32'h1234_5678};
        step();
        chk("capt_valid", {63'h0, o_valid}, 64'h1);
        chk("capt_data", {32'h0, o_data}, 64'h1234_5678);
        chk("capt_cnts", {16'h0, o_bub, o_hold, o_fl}, 64'h0);

        // Bubble twice then hold three times; u_top is the last stage.
        stall = 6'b010000;
        step();
        step();
        chk("bub_valid", {63'h0, o_valid}, 64'h0);
        chk("bub_data", {32'h0, o_data}, 64'h0);
        chk("bub_cnt", {48'h0, o_bub}, 64'd2);
        chk("top_capt_valid", {63'h0, h_valid}, 64'h1);
        stall = 6'b110000;
        repeat (3) step();
        chk("hold_valid", {63'h0, o_valid}, 64'h0);
        chk("hold_cnt", {48'h0, o_hold}, 64'd3);
        chk("hold_bub_cnt", {48'h0, o_bub}, 64'd2);
        chk("top_bub_valid", {63'h0, h_valid}, 64'h0);
        chk("top_bub_data", {32'h0, h_data}, 64'h1234_5678);
        chk("top_cnts", {16'h0, h_bub, h_hold, h_fl}, {16'h0, 16'd3, 16'd0, 16'd0});

        // Flush beats a bubble-producing stall.
        stall = 6'b010000; flush = 1'b1;
        step();
        chk("fl_valid", {63'h0, o_valid}, 64'h0);
        chk("fl_cnt", {48'h0, o_fl}, 64'd1);
        chk("fl_bub_cnt", {48'h0, o_bub}, 64'd2);
        chk("top_fl_data", {32'h0, h_data}, 64'h1234_5678);
        chk("top_fl_cnt", {48'h0, h_fl}, 64'd1);
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
